// File: rtl/pc_flow_pkg.sv
// -----------------------------------------------------------------------------
// pc_flow_pkg
// Shared types and constants for the fetch-stage PC flow controller.
//   pc_state_e   : controller FSM states. The encoding is visible on o_state.
//   redir_src_e  : redirect-source priority. A larger value means a higher
//                  priority, so sources can be compared with >=.
//   PC_INCR      : sequential fetch increment.
//   redir_src_of : maps the raw redirect requests to their priority code.
// -----------------------------------------------------------------------------
package pc_flow_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_STALL  = 2'd1,
    ST_IMEM_WAIT = 2'd2,
    ST_REDIRECT  = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_JUMP   = 2'd1,
    SRC_BRANCH = 2'd2,
    SRC_EXC    = 2'd3
  } redir_src_e;

  localparam logic [31:0] PC_INCR     = 32'd4;
  localparam int          STALL_CNT_W = 3;

  // An exception outranks a branch resolved in EX, which outranks a jump in ID.
  function automatic redir_src_e redir_src_of(input logic exc,
                                              input logic branch_taken,
                                              input logic jump);
    if (exc)               return SRC_EXC;
    else if (branch_taken) return SRC_BRANCH;
    else if (jump)         return SRC_JUMP;
    else                   return SRC_NONE;
  endfunction

endpackage

// File: rtl/pc_flow_hazard_det.sv
// -----------------------------------------------------------------------------
// pc_flow_hazard_det
// Combinational load-use hazard comparator. It flags the case where the load
// in EX writes a register that the instruction in ID reads. Register 0 is
// hard-wired to zero, so it never creates a dependency. The forwarding unit
// can reuse this block.
// Ports:
//   i_idex_memread : instruction in EX is a load
//   i_idex_rt      : load destination register
//   i_ifid_rs      : first source register of the instruction in ID
//   i_ifid_rt      : second source register of the instruction in ID
//   o_lu_haz       : load-use hazard detected
// -----------------------------------------------------------------------------
module pc_flow_hazard_det (
  input  logic       i_idex_memread,
  input  logic [4:0] i_idex_rt,
  input  logic [4:0] i_ifid_rs,
  input  logic [4:0] i_ifid_rt,
  output logic       o_lu_haz
);

  logic w_rt_nonzero;
  logic w_rt_match;

  assign w_rt_nonzero = (i_idex_rt != 5'd0);
  assign w_rt_match   = (i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt);
  assign o_lu_haz     = i_idex_memread & w_rt_nonzero & w_rt_match;

endmodule

// File: rtl/pc_flow_ctrl.sv
// -----------------------------------------------------------------------------
// pc_flow_ctrl
// Sequencing controller for the fetch-stage PC register and the IF/ID and
// ID/EX pipeline registers. It selects the next PC from the exception, branch,
// jump or sequential sources. It sequences load-use stalls, instruction-memory
// wait states and control-flow redirects. A redirect that arrives while a
// fetch is outstanding is latched and applied once the memory responds.
// All outputs are combinational from the state and the inputs.
//
// Ports:
//   i_clk, i_rst          : clock (rising edge), asynchronous active-high reset
//   i_pc                  : current PC from the PC register
//   i_imem_ready          : instruction memory has valid data for i_pc
//   i_idex_memread/_rt    : load in EX and its destination register
//   i_ifid_rs/_rt         : source registers of the instruction in ID
//   i_branch_taken/target : branch resolved taken in EX
//   i_jump/_target        : jump decoded in ID
//   i_exc                 : exception request
//   o_next_pc             : next-PC value for the PC register
//   o_pcwrite             : PC register write enable
//   o_ifid_write          : IF/ID write enable
//   o_ifid_flush          : load a NOP into IF/ID
//   o_idex_bubble         : zero the ID/EX control fields
//   o_state               : FSM state (RUN=0, LU_STALL=1, IMEM_WAIT=2, REDIRECT=3)
//
// Optional build macro PC_FLOW_PERF_EN adds two wrapping 32-bit counters:
//   o_stall_cycles : cycles out of reset with o_pcwrite=0
//   o_redirects    : redirects actually written into the PC
// -----------------------------------------------------------------------------
module pc_flow_ctrl
  import pc_flow_pkg::*;
#(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC      = 32'h0000_0180,
  parameter int          LU_STALL_CYC = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_imem_ready,
  input  logic        i_idex_memread,
  input  logic [4:0]  i_idex_rt,
  input  logic [4:0]  i_ifid_rs,
  input  logic [4:0]  i_ifid_rt,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_exc,
  output logic [31:0] o_next_pc,
  output logic        o_pcwrite,
  output logic        o_ifid_write,
  output logic        o_ifid_flush,
  output logic        o_idex_bubble,
  output logic [1:0]  o_state
`ifdef PC_FLOW_PERF_EN
  ,
  output logic [31:0] o_stall_cycles,
  output logic [31:0] o_redirects
`endif
);

  pc_state_e              r_state;
  logic                   r_pend_vld;
  logic [31:0]            r_pend_pc;
  redir_src_e             r_pend_src;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  pc_state_e              w_state_nxt;
  logic                   w_pend_vld_nxt;
  logic [31:0]            w_pend_pc_nxt;
  redir_src_e             w_pend_src_nxt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;

  logic                   w_redirect;
  redir_src_e             w_redir_src;
  logic [31:0]            w_redir_pc;
  logic                   w_lu_haz;
  logic                   w_take_new;
  logic                   w_redir_applied;

  pc_flow_hazard_det u_hazard_det (
    .i_idex_memread (i_idex_memread),
    .i_idex_rt      (i_idex_rt),
    .i_ifid_rs      (i_ifid_rs),
    .i_ifid_rt      (i_ifid_rt),
    .o_lu_haz       (w_lu_haz)
  );

  assign w_redirect  = i_exc | i_branch_taken | i_jump;
  assign w_redir_src = redir_src_of(i_exc, i_branch_taken, i_jump);

  always_comb begin
    w_redir_pc = i_jump_target;
    if (i_exc)               w_redir_pc = EXC_VEC;
    else if (i_branch_taken) w_redir_pc = i_branch_target;
  end

  // While a fetch is outstanding, a new redirect replaces the latched one
  // only if its priority is at least as high.
  assign w_take_new = w_redirect && (!r_pend_vld || (w_redir_src >= r_pend_src));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_RUN;
      r_pend_vld  <= 1'b0;
      r_pend_pc   <= 32'd0;
      r_pend_src  <= SRC_NONE;
      r_stall_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_pc   <= w_pend_pc_nxt;
      r_pend_src  <= w_pend_src_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  always_comb begin
    o_next_pc       = i_pc + PC_INCR;
    o_pcwrite       = 1'b1;
    o_ifid_write    = 1'b1;
    o_ifid_flush    = 1'b0;
    o_idex_bubble   = 1'b0;
    o_state         = r_state;
    w_state_nxt     = r_state;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_pc_nxt   = r_pend_pc;
    w_pend_src_nxt  = r_pend_src;
    w_stall_cnt_nxt = r_stall_cnt;
    w_redir_applied = 1'b0;

    if (i_rst) begin
      o_next_pc     = RESET_VEC;
      o_pcwrite     = 1'b0;
      o_ifid_write  = 1'b0;
      o_ifid_flush  = 1'b1;
      o_idex_bubble = 1'b1;
      o_state       = ST_RUN;
    end else if (r_state == ST_IMEM_WAIT) begin
      o_pcwrite    = 1'b0;
      o_ifid_flush = 1'b1;
      if (w_take_new) begin
        w_pend_vld_nxt = 1'b1;
        w_pend_pc_nxt  = w_redir_pc;
        w_pend_src_nxt = w_redir_src;
      end
      // A redirect that arrives in the same cycle as the memory response
      // is merged above, so it is applied on this response.
      if (i_imem_ready) begin
        if (w_pend_vld_nxt) begin
          o_next_pc       = w_pend_pc_nxt;
          o_pcwrite       = 1'b1;
          w_pend_vld_nxt  = 1'b0;
          w_pend_src_nxt  = SRC_NONE;
          w_state_nxt     = ST_REDIRECT;
          w_redir_applied = 1'b1;
        end else begin
          o_pcwrite    = 1'b1;
          o_ifid_flush = 1'b0;
          w_state_nxt  = ST_RUN;
        end
      end
    end else begin
      // RUN, LU_STALL and REDIRECT share the redirect handling. In REDIRECT
      // the instruction in ID is squashed, so its hazard is ignored.
      if (r_state == ST_REDIRECT) o_idex_bubble = 1'b1;

      if (w_redirect) begin
        o_ifid_flush = 1'b1;
        if (i_imem_ready) begin
          o_next_pc       = w_redir_pc;
          w_state_nxt     = ST_REDIRECT;
          w_redir_applied = 1'b1;
        end else begin
          o_pcwrite      = 1'b0;
          w_pend_vld_nxt = 1'b1;
          w_pend_pc_nxt  = w_redir_pc;
          w_pend_src_nxt = w_redir_src;
          w_state_nxt    = ST_IMEM_WAIT;
        end
      end else if (r_state == ST_LU_STALL) begin
        o_pcwrite     = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b1;
        if (r_stall_cnt == '0) w_state_nxt = ST_RUN;
        else                   w_stall_cnt_nxt = r_stall_cnt - STALL_CNT_W'(1);
      end else if ((r_state == ST_RUN) && w_lu_haz) begin
        o_pcwrite     = 1'b0;
        o_ifid_write  = 1'b0;
        o_idex_bubble = 1'b1;
        // The first stall cycle is spent in RUN. The counter therefore holds
        // the number of further LU_STALL cycles minus one.
        if (LU_STALL_CYC > 1) begin
          w_stall_cnt_nxt = STALL_CNT_W'(LU_STALL_CYC - 2);
          w_state_nxt     = ST_LU_STALL;
        end
      end else if ((r_state == ST_RUN) && !i_imem_ready) begin
        o_pcwrite    = 1'b0;
        o_ifid_flush = 1'b1;
        w_state_nxt  = ST_IMEM_WAIT;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end
  end

`ifdef PC_FLOW_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_redirects;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cycles <= 32'd0;
      r_redirects    <= 32'd0;
    end else begin
      if (!o_pcwrite)      r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_redir_applied) r_redirects    <= r_redirects + 32'd1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_redirects    = r_redirects;
`endif

endmodule

// File: tb/tb_pc_flow_ctrl.sv
module tb_pc_flow_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0180;
  localparam int          LU = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        ready;
  logic        memread;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        br;
  logic [31:0] bt;
  logic        jmp;
  logic [31:0] jt;
  logic        exc;

  logic [31:0] o_next_pc;
  logic        o_pcwrite, o_ifid_write, o_ifid_flush, o_idex_bubble;
  logic [1:0]  o_state;
`ifdef PC_FLOW_PERF_EN
  logic [31:0] o_stall_cycles, o_redirects;
`endif

  always #5 clk = ~clk;

  pc_flow_ctrl #(.RESET_VEC(RV), .EXC_VEC(EV), .LU_STALL_CYC(LU)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_imem_ready(ready),
    .i_idex_memread(memread), .i_idex_rt(idex_rt), .i_ifid_rs(ifid_rs),
    .i_ifid_rt(ifid_rt), .i_branch_taken(br), .i_branch_target(bt),
    .i_jump(jmp), .i_jump_target(jt), .i_exc(exc),
    .o_next_pc(o_next_pc), .o_pcwrite(o_pcwrite), .o_ifid_write(o_ifid_write),
    .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble), .o_state(o_state)
`ifdef PC_FLOW_PERF_EN
    , .o_stall_cycles(o_stall_cycles), .o_redirects(o_redirects)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: mode (0 run, 1 stalled, 2 waiting for imem, 3 just
  // redirected), stall cycles still owed, and the latched outstanding redirect.
  int          m_mode, m_left, m_psrc;
  bit          m_pv;
  logic [31:0] m_ppc;
  int          n_mode, n_left, n_psrc;
  bit          n_pv;
  logic [31:0] n_ppc;
  logic [31:0] e_npc;
  logic        e_pcw, e_ifw, e_fl, e_bub;
  logic [1:0]  e_st;
  logic [37:0] exp_v, act;

  assign act = {o_next_pc, o_pcwrite, o_ifid_write, o_ifid_flush, o_idex_bubble, o_state};

  task automatic model_eval();
    bit redir, haz;
    int rsrc;
    logic [31:0] rpc;
    redir = exc || br || jmp;
    rsrc  = exc ? 3 : (br ? 2 : (jmp ? 1 : 0));
    rpc   = exc ? EV : (br ? bt : jt);
    haz   = memread && (idex_rt != 0) && ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    e_npc = pc + 32'd4; e_pcw = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_st = 2'(m_mode);
    n_mode = m_mode; n_left = m_left; n_pv = m_pv; n_ppc = m_ppc; n_psrc = m_psrc;
    if (rst) begin
      e_npc = RV; e_pcw = 0; e_ifw = 0; e_fl = 1; e_bub = 1; e_st = 0;
      n_mode = 0; n_left = 0; n_pv = 0; n_ppc = 0; n_psrc = 0;
    end else if (m_mode == 2) begin
      e_pcw = 0; e_fl = 1;
      if (redir && (!m_pv || rsrc >= m_psrc)) begin n_pv = 1; n_ppc = rpc; n_psrc = rsrc; end
      if (ready) begin
        if (n_pv) begin e_npc = n_ppc; e_pcw = 1; n_pv = 0; n_psrc = 0; n_mode = 3; end
        else begin e_pcw = 1; e_fl = 0; n_mode = 0; end
      end
    end else begin
      if (m_mode == 3) e_bub = 1;
      if (redir) begin
        e_fl = 1;
        if (ready) begin e_npc = rpc; n_mode = 3; n_left = 0; end
        else begin e_pcw = 0; n_pv = 1; n_ppc = rpc; n_psrc = rsrc; n_mode = 2; n_left = 0; end
      end else if (m_mode == 1) begin
        e_pcw = 0; e_ifw = 0; e_bub = 1;
        n_left = m_left - 1; n_mode = (n_left == 0) ? 0 : 1;
      end else if (m_mode == 0 && haz) begin
        e_pcw = 0; e_ifw = 0; e_bub = 1;
        n_left = LU - 1; n_mode = (n_left > 0) ? 1 : 0;
      end else if (m_mode == 0 && !ready) begin
        e_pcw = 0; e_fl = 1; n_mode = 2;
      end else begin
        n_mode = 0;
      end
    end
    exp_v = {e_npc, e_pcw, e_ifw, e_fl, e_bub, e_st};
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    m_mode = n_mode; m_left = n_left; m_pv = n_pv; m_ppc = n_ppc; m_psrc = n_psrc;
    if (e_pcw) pc = e_npc;
    #1;
  endtask

  task automatic quiet_inputs();
    memread = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    br = 0; bt = 0; jmp = 0; jt = 0; exc = 0; ready = 1;
  endtask

  task automatic idle(input int n);
    quiet_inputs();
    for (int i = 0; i < n; i++) begin settle(); tick(); end
  endtask

  task automatic test_reset();
    rst = 1; quiet_inputs(); pc = 32'h1234;
    settle();
    checks++;
    if (act !== exp_v) begin failures++; $display("FAIL reset_model got=%h want=%h", act, exp_v); end
    checks++;
    if (o_next_pc !== RV || o_pcwrite !== 1'b0 || o_ifid_write !== 1'b0 ||
        o_ifid_flush !== 1'b1 || o_idex_bubble !== 1'b1 || o_state !== 2'd0) begin
      failures++; $display("FAIL reset_outputs got=%h want npc=%h pcw=0 ifw=0 fl=1 bub=1 st=0", act, RV);
    end
    tick();
    rst = 0; pc = 32'd0;
    settle();
    checks++;
    if (act !== exp_v) begin failures++; $display("FAIL release_model got=%h want=%h", act, exp_v); end
    checks++;
    if (o_next_pc !== 32'd4 || o_pcwrite !== 1'b1 || o_state !== 2'd0) begin
      failures++; $display("FAIL release_fetch got npc=%h pcw=%b st=%0d want npc=4 pcw=1 st=0", o_next_pc, o_pcwrite, o_state);
    end
    tick();
  endtask

  task automatic test_load_use();
    int stalls = 0;
    memread = 1; idex_rt = 5; ifid_rs = 5; ifid_rt = 0;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL lu_model c=%0d got=%h want=%h", c, act, exp_v); end
      if (o_pcwrite === 1'b0 && o_idex_bubble === 1'b1) stalls++;
      tick();
      memread = 0; idex_rt = 0; ifid_rs = 0;
    end
    checks++;
    if (stalls !== LU) begin failures++; $display("FAIL lu_stall_len got=%0d want=%0d", stalls, LU); end
    checks++;
    if (o_state !== 2'd0) begin failures++; $display("FAIL lu_back_to_run got=%0d want=0", o_state); end
    memread = 1; idex_rt = 0; ifid_rs = 0;
    settle();
    checks++;
    if (o_pcwrite !== 1'b1 || o_idex_bubble !== 1'b0) begin
      failures++; $display("FAIL lu_rt_zero got pcw=%b bub=%b want pcw=1 bub=0", o_pcwrite, o_idex_bubble);
    end
    tick();
    idle(1);
  endtask

  task automatic test_branch();
    br = 1; bt = 32'h40;
    settle();
    checks++;
    if (o_next_pc !== 32'h40 || o_ifid_flush !== 1'b1 || act !== exp_v) begin
      failures++; $display("FAIL branch_same_cycle got=%h want=%h", act, exp_v);
    end
    tick();
    br = 0;
    settle();
    checks++;
    if (o_state !== 2'd3 || o_idex_bubble !== 1'b1 || act !== exp_v) begin
      failures++; $display("FAIL branch_redirect_state got=%h want=%h", act, exp_v);
    end
    tick();
    settle();
    checks++;
    if (o_state !== 2'd0) begin failures++; $display("FAIL branch_back_to_run got=%0d want=0", o_state); end
    tick();
  endtask

  task automatic test_imem_wait();
    int held = 0;
    ready = 0;
    for (int c = 0; c < 4; c++) begin
      br = (c == 1); bt = 32'h80;
      settle();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL wait_model c=%0d got=%h want=%h", c, act, exp_v); end
      if (o_pcwrite === 1'b0) held++;
      tick();
    end
    checks++;
    if (held !== 4) begin failures++; $display("FAIL wait_hold got=%0d want=4", held); end
    br = 0; ready = 1;
    settle();
    checks++;
    if (o_next_pc !== 32'h80 || o_pcwrite !== 1'b1) begin
      failures++; $display("FAIL wait_release got npc=%h pcw=%b want npc=80 pcw=1", o_next_pc, o_pcwrite);
    end
    tick();
    settle();
    checks++;
    if (o_state !== 2'd3) begin failures++; $display("FAIL wait_then_redirect got=%0d want=3", o_state); end
    tick();
    idle(1);
  endtask

  task automatic test_wait_priority();
    logic [31:0] want [2] = '{32'h100, 32'h180};
    for (int k = 0; k < 2; k++) begin
      ready = 0;
      for (int c = 0; c < 3; c++) begin
        br  = (k == 0 && c == 0); bt = 32'h100;
        jmp = (k == 0 && c == 1) || (k == 1 && c == 0); jt = (k == 0) ? 32'h200 : 32'h300;
        exc = (k == 1 && c == 1);
        settle(); tick();
      end
      br = 0; jmp = 0; exc = 0; ready = 1;
      settle();
      checks++;
      if (o_next_pc !== want[k] || act !== exp_v) begin
        failures++; $display("FAIL wait_priority k=%0d got npc=%h want=%h", k, o_next_pc, want[k]);
      end
      tick();
      idle(1);
    end
  endtask

  task automatic test_exc_in_stall();
    memread = 1; idex_rt = 7; ifid_rt = 7;
    settle(); tick();
    memread = 0; idex_rt = 0; ifid_rt = 0;
    exc = 1; br = 1; bt = 32'h40;
    settle();
    checks++;
    if (o_next_pc !== EV || o_ifid_flush !== 1'b1 || o_pcwrite !== 1'b1 || act !== exp_v) begin
      failures++; $display("FAIL exc_abort_stall got=%h want=%h", act, exp_v);
    end
    tick();
    exc = 0; br = 0;
    settle();
    checks++;
    if (o_state !== 2'd3) begin failures++; $display("FAIL exc_redirect_state got=%0d want=3", o_state); end
    tick();
    idle(1);
  endtask

  task automatic test_reset_mid_wait();
    ready = 0; br = 1; bt = 32'h80;
    settle(); tick();
    br = 0;
    settle();
    checks++;
    if (o_state !== 2'd2) begin failures++; $display("FAIL rstwait_in_wait got=%0d want=2", o_state); end
    rst = 1;
    settle();
    checks++;
    if (o_state !== 2'd0 || o_next_pc !== RV || o_pcwrite !== 1'b0 || act !== exp_v) begin
      failures++; $display("FAIL rstwait_reset got=%h want=%h", act, exp_v);
    end
    tick();
    rst = 0; ready = 1;
    settle();
    checks++;
    if (o_next_pc !== pc + 32'd4 || o_pcwrite !== 1'b1 || o_state !== 2'd0) begin
      failures++; $display("FAIL rstwait_no_stale got npc=%h pcw=%b st=%0d want npc=%h", o_next_pc, o_pcwrite, o_state, pc + 32'd4);
    end
    tick();
    settle();
    checks++;
    if (o_state !== 2'd0) begin failures++; $display("FAIL rstwait_stays_run got=%0d want=0", o_state); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst     = ($urandom_range(0, 99) < 2);
      ready   = ($urandom_range(0, 99) < 75);
      memread = ($urandom_range(0, 99) < 35);
      idex_rt = 5'($urandom_range(0, 3));
      ifid_rs = 5'($urandom_range(0, 3));
      ifid_rt = 5'($urandom_range(0, 3));
      br      = ($urandom_range(0, 99) < 12);
      jmp     = ($urandom_range(0, 99) < 12);
      exc     = ($urandom_range(0, 99) < 5);
      bt      = {$urandom()} & 32'hFFFF_FFFC;
      jt      = {$urandom()} & 32'hFFFF_FFFC;
      settle();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL random c=%0d got=%h want=%h", c, act, exp_v); end
      tick();
    end
    rst = 0;
    idle(6);
  endtask

  initial begin
    m_mode = 0; m_left = 0; m_pv = 0; m_ppc = 0; m_psrc = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_imem_wait();
    test_wait_priority();
    test_exc_in_stall();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
